// File: rtl/mem_line_arbiter.sv
// ============================================================================
// Module      : mem_line_arbiter
// Description : Round-robin arbiter sharing one fixed-latency line memory port
//               between I-cache refills and D-cache refills/writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_line_arbiter #(
   parameter  int XLEN           = 32,
   parameter  int LINE_WORDS     = 4,
   parameter  int LINE_ADDR_BITS = 6,
   parameter  int MEM_LATENCY    = 4,
   localparam int LINE_BITS      = XLEN * LINE_WORDS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ic_req,
   input  logic [LINE_ADDR_BITS-1:0] ic_addr,
   output logic                      ic_done,
   output logic [LINE_BITS-1:0]      ic_rdata,
   input  logic                      dc_req,
   input  logic                      dc_we,
   input  logic [LINE_ADDR_BITS-1:0] dc_addr,
   input  logic [LINE_BITS-1:0]      dc_wdata,
   output logic                      dc_done,
   output logic [LINE_BITS-1:0]      dc_rdata,
   output logic [LINE_ADDR_BITS-1:0] mem_addr,
   output logic                      mem_we,
   output logic [LINE_BITS-1:0]      mem_wdata,
   input  logic [LINE_BITS-1:0]      mem_rdata,
   output logic                      busy
);

   localparam int              c_CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY - 1);
   localparam logic            c_SRC_I    = 1'b0;
   localparam logic            c_SRC_D    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               r_owner;
   logic               r_last_grant;
   logic               r_wflag;
   logic               w_grant_d;
   logic               w_start;
   logic               w_capture;
   logic               w_we_nxt;
   logic               w_ic_done_nxt;
   logic               w_dc_done_nxt;

   // On a collision D wins only if I was granted last.
   assign w_grant_d = dc_req & (~ic_req | (r_last_grant == c_SRC_I));

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_start       = 1'b0;
      w_capture     = 1'b0;
      w_we_nxt      = 1'b0;
      w_ic_done_nxt = 1'b0;
      w_dc_done_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ic_req | dc_req) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = c_CNT_LOAD;
               w_we_nxt    = (c_CNT_LOAD == '0) & w_grant_d & dc_we;
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt   = ST_RESP;
               w_capture     = ~r_wflag;
               w_ic_done_nxt = (r_owner == c_SRC_I);
               w_dc_done_nxt = (r_owner == c_SRC_D);
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
               // Registered strobe lands exactly on the counter==0 cycle.
               w_we_nxt  = (r_cnt == c_CNT_W'(1)) & r_wflag;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         mem_we  <= 1'b0;
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         mem_we  <= w_we_nxt;
         ic_done <= w_ic_done_nxt;
         dc_done <= w_dc_done_nxt;
         busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= c_SRC_I;
         r_last_grant <= c_SRC_D;
         r_wflag      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         ic_rdata     <= '0;
         dc_rdata     <= '0;
      end else begin
         if (w_start) begin
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_wflag      <= w_grant_d & dc_we;
            mem_addr     <= w_grant_d ? dc_addr : ic_addr;
            if (w_grant_d) begin
               mem_wdata <= dc_wdata;
            end
         end
         if (w_capture) begin
            if (r_owner == c_SRC_D) begin
               dc_rdata <= mem_rdata;
            end else begin
               ic_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

`default_nettype wire
